// File: rtl/mul_iter_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the EX stage.
// It adds one partial product per cycle in carry-save form, then resolves the pair with one carry-propagate add.
module mul_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       mulop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int AccW = 2*WIDTH + 1;
  localparam int CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, RESOLVE, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH:0]    a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [AccW-1:0]   sum_q, sum_d;
  // The carry vector is always used shifted left by one, so its top bit could never matter.
  logic [AccW-2:0]   carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic [AccW-1:0]   term, pp, cin;
  logic              last, pbit;
  logic [2*WIDTH-1:0] product;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !kill) state_d = CALC;
      CALC:    if (kill) state_d = IDLE;
               else if (last) state_d = RESOLVE;
      RESOLVE: state_d = kill ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == RESOLVE);
    done = (state_q == DONE);
  end

  assign result = result_q;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    last = (cnt_q == CntW'(WIDTH));
    pbit = b_q[cnt_q];
    term = {{WIDTH{a_q[WIDTH]}}, a_q} << cnt_q;
    // The b sign-bit weight is negative: invert the term here and add the +1 through the free carry LSB.
    pp   = pbit ? (last ? ~term : term) : '0;
    cin  = {carry_q, pbit & last};
    // Low 64 bits of the 65-bit resolve, which are all the result ever uses.
    product = sum_q[2*WIDTH-1:0] + {carry_q[2*WIDTH-2:0], 1'b0};

    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          a_d     = {a[WIDTH-1] & (mulop != 2'b11), a};
          b_d     = {b[WIDTH-1] & ~mulop[1], b};
          op_d    = mulop;
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        sum_d   = sum_q ^ cin ^ pp;
        carry_d = (sum_q[AccW-2:0] & cin[AccW-2:0]) |
                  (sum_q[AccW-2:0] & pp[AccW-2:0])  |
                  (cin[AccW-2:0]   & pp[AccW-2:0]);
        cnt_d   = cnt_q + CntW'(1);
      end
      RESOLVE: begin
        if (!kill)
          result_d = (op_q == 2'b00) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

endmodule
